// File: rtl/exec_unit_mc_pkg.sv
// Shared types for the multi-cycle execution unit: opcode map, iteration kinds
// and the control FSM state encoding.
package exec_unit_mc_pkg;

   typedef enum logic [3:0] {
      OP_NOP       = 4'd0,
      OP_MOV_R_R   = 4'd1,
      OP_MOV_R_IMM = 4'd2,
      OP_IN_R      = 4'd3,
      OP_OUT_R     = 4'd4,
      OP_OUT_IMM   = 4'd5,
      OP_ADD_R_IMM = 4'd6,
      OP_ADD_R_R   = 4'd7,
      OP_SUB_R_R   = 4'd8,
      OP_JMP_IMM   = 4'd9,
      OP_JNC_IMM   = 4'd10,
      OP_SHL_R_IMM = 4'd11,
      OP_MUL_R_R   = 4'd12
   } exec_op_e;

   typedef enum logic {
      ITER_SHL = 1'b0,
      ITER_MUL = 1'b1
   } iter_kind_e;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ITER = 1'b1
   } exec_state_e;

   // A shift by zero retires in one cycle like any ALU op; only real work iterates.
   function automatic logic is_multi_cycle(input exec_op_e op, input logic shl_nonzero);
      return (op == OP_MUL_R_R) || ((op == OP_SHL_R_IMM) && shl_nonzero);
   endfunction

endpackage

// File: rtl/exec_unit_mc_iter_datapath.sv
// Iterative engine: one-bit-per-cycle left shift, or unsigned shift-add multiply.
// The final step's result is presented combinationally so the owner can commit on the last edge.
module iter_datapath
   import exec_unit_mc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  iter_kind_e        kind,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [CNT_W-1:0]  count,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              last
);

   iter_kind_e          r_kind;
   logic [2*DATA_W-1:0] r_acc;
   logic [2*DATA_W-1:0] r_mcand;
   logic [DATA_W-1:0]   r_mplier;
   logic [CNT_W-1:0]    r_cnt;

   logic [2*DATA_W-1:0] w_acc_next;
   logic                w_shift_out;

   // SHL keeps its operand in the low half of the accumulator; MUL builds the full product there.
   always_comb begin
      w_acc_next  = r_acc;
      w_shift_out = 1'b0;
      if (r_kind == ITER_SHL) begin
         w_acc_next  = {{DATA_W{1'b0}}, r_acc[DATA_W-2:0], 1'b0};
         w_shift_out = r_acc[DATA_W-1];
      end else if (r_mplier[0]) begin
         w_acc_next = r_acc + r_mcand;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_kind   <= ITER_SHL;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_cnt    <= '0;
      end else if (start) begin
         r_kind <= kind;
         r_cnt  <= count;
         if (kind == ITER_SHL) begin
            r_acc    <= {{DATA_W{1'b0}}, a};
            r_mcand  <= '0;
            r_mplier <= '0;
         end else begin
            r_acc    <= '0;
            r_mcand  <= {{DATA_W{1'b0}}, a};
            r_mplier <= b;
         end
      end else if (r_cnt != '0) begin
         r_acc    <= w_acc_next;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
         r_cnt    <= r_cnt - CNT_W'(1);
      end
   end

   assign result    = w_acc_next[DATA_W-1:0];
   assign carry_out = (r_kind == ITER_SHL) ? w_shift_out : (|w_acc_next[2*DATA_W-1:DATA_W]);
   assign last      = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution unit: owns registers, PC, output port and carry, and
// retires one decoded instruction per valid/ready handshake.
module exec_unit_mc
   import exec_unit_mc_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int PC_W     = 8,
   localparam int RIDX_W  = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  exec_op_e          op,
   input  logic [RIDX_W-1:0] rd,
   input  logic [RIDX_W-1:0] rs,
   input  logic [DATA_W-1:0] imm,
   input  logic [DATA_W-1:0] switch_in,
   output logic              done,
   output logic              busy,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] out_port,
   output logic              carry
);

   localparam int SH_W  = $clog2(DATA_W);
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [PC_W-1:0]   r_pc;
   logic [DATA_W-1:0] r_out;
   logic              r_carry;
   logic              r_done;
   logic [RIDX_W-1:0] r_dst;
   exec_state_e       r_state;
   exec_state_e       w_state_next;

   logic              w_accept;
   logic              w_multi;
   logic [SH_W-1:0]   w_shamt;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W:0]   w_add_imm;
   logic [DATA_W:0]   w_add_rr;
   logic [DATA_W:0]   w_sub_rr;
   logic [PC_W-1:0]   w_pc_inc;
   logic [PC_W-1:0]   w_jmp_target;
   iter_kind_e        w_kind;
   logic [CNT_W-1:0]  w_count;
   logic [DATA_W-1:0] w_it_result;
   logic              w_it_carry;
   logic              w_it_last;

   assign w_a          = r_regs[rd];
   assign w_b          = r_regs[rs];
   assign w_shamt      = imm[SH_W-1:0];
   assign w_accept     = req_valid && (r_state == S_IDLE);
   assign w_multi      = is_multi_cycle(op, w_shamt != '0);
   assign w_add_imm    = {1'b0, w_a} + {1'b0, imm};
   assign w_add_rr     = {1'b0, w_a} + {1'b0, w_b};
   assign w_sub_rr     = {1'b0, w_a} - {1'b0, w_b};
   assign w_pc_inc     = r_pc + PC_W'(1);
   assign w_jmp_target = PC_W'(imm);
   assign w_kind       = (op == OP_MUL_R_R) ? ITER_MUL : ITER_SHL;
   assign w_count      = (op == OP_MUL_R_R) ? CNT_W'(DATA_W) : CNT_W'(w_shamt);

   iter_datapath #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_iter (
      .clk       (clk),
      .rst       (rst),
      .start     (w_accept && w_multi),
      .kind      (w_kind),
      .a         (w_a),
      .b         (w_b),
      .count     (w_count),
      .result    (w_it_result),
      .carry_out (w_it_carry),
      .last      (w_it_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept && w_multi) w_state_next = S_ITER;
         S_ITER:  if (w_it_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // Single-cycle ops commit at the accept edge; iterative ops only latch their
   // destination there and commit everything on the final ITER edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
         r_pc    <= '0;
         r_out   <= '0;
         r_carry <= 1'b0;
         r_done  <= 1'b0;
         r_dst   <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_accept) begin
            if (w_multi) begin
               r_dst <= rd;
            end else begin
               r_done  <= 1'b1;
               r_carry <= 1'b0;
               r_pc    <= w_pc_inc;
               case (op)
                  OP_MOV_R_R:   r_regs[rd] <= w_b;
                  OP_MOV_R_IMM: r_regs[rd] <= imm;
                  OP_IN_R:      r_regs[rd] <= switch_in;
                  OP_OUT_R:     r_out <= w_a;
                  OP_OUT_IMM:   r_out <= imm;
                  OP_ADD_R_IMM: {r_carry, r_regs[rd]} <= w_add_imm;
                  OP_ADD_R_R:   {r_carry, r_regs[rd]} <= w_add_rr;
                  OP_SUB_R_R:   {r_carry, r_regs[rd]} <= w_sub_rr;
                  OP_JMP_IMM:   r_pc <= w_jmp_target;
                  OP_JNC_IMM:   if (!r_carry) r_pc <= w_jmp_target;
                  default:      ;
               endcase
            end
         end else if ((r_state == S_ITER) && w_it_last) begin
            r_regs[r_dst] <= w_it_result;
            r_carry       <= w_it_carry;
            r_pc          <= w_pc_inc;
            r_done        <= 1'b1;
         end
      end
   end

   assign req_ready = (r_state == S_IDLE);
   assign busy      = (r_state == S_ITER);
   assign done      = r_done;
   assign pc        = r_pc;
   assign out_port  = r_out;
   assign carry     = r_carry;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed and randomized bench for exec_unit_mc, checked against an
// instruction-level reference model of the architectural state.
module tb_exec_unit_mc;
   import exec_unit_mc_pkg::*;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   exec_op_e   op;
   logic [1:0] rd;
   logic [1:0] rs;
   logic [7:0] imm;
   logic [7:0] switch_in;
   logic       done;
   logic       busy;
   logic [7:0] pc;
   logic [7:0] out_port;
   logic       carry;

   int assertCount = 0;
   int failCount   = 0;

   int mRegs [4];
   int mPc;
   int mOut;
   int mCarry;

   exec_unit_mc #(
      .DATA_W   (8),
      .NUM_REGS (4),
      .PC_W     (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .op        (op),
      .rd        (rd),
      .rs        (rs),
      .imm       (imm),
      .switch_in (switch_in),
      .done      (done),
      .busy      (busy),
      .pc        (pc),
      .out_port  (out_port),
      .carry     (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      assertCount++;
      assert (obs === exp) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) mRegs[i] = 0;
      mPc    = 0;
      mOut   = 0;
      mCarry = 0;
   endtask

   // Architectural effect of one instruction, plus its accept-to-done latency.
   task automatic modelExec(input exec_op_e o, input int d, input int s, input int im,
                            input int sw, output int lat);
      int prod;
      int n;
      int nextPc;
      lat    = 1;
      nextPc = (mPc + 1) % 256;
      case (o)
         OP_MOV_R_R:   begin mRegs[d] = mRegs[s]; mCarry = 0; end
         OP_MOV_R_IMM: begin mRegs[d] = im; mCarry = 0; end
         OP_IN_R:      begin mRegs[d] = sw; mCarry = 0; end
         OP_OUT_R:     begin mOut = mRegs[d]; mCarry = 0; end
         OP_OUT_IMM:   begin mOut = im; mCarry = 0; end
         OP_ADD_R_IMM: begin
            prod = mRegs[d] + im;
            mCarry = (prod > 255) ? 1 : 0;
            mRegs[d] = prod % 256;
         end
         OP_ADD_R_R: begin
            prod = mRegs[d] + mRegs[s];
            mCarry = (prod > 255) ? 1 : 0;
            mRegs[d] = prod % 256;
         end
         OP_SUB_R_R: begin
            mCarry = (mRegs[d] < mRegs[s]) ? 1 : 0;
            mRegs[d] = (mRegs[d] - mRegs[s] + 256) % 256;
         end
         OP_JMP_IMM: begin nextPc = im; mCarry = 0; end
         OP_JNC_IMM: begin
            if (mCarry == 0) nextPc = im;
            mCarry = 0;
         end
         OP_SHL_R_IMM: begin
            n = im % 8;
            if (n == 0) begin
               mCarry = 0;
            end else begin
               prod = mRegs[d] * (1 << n);
               mCarry = (prod / 256) % 2;
               mRegs[d] = prod % 256;
               lat = n + 1;
            end
         end
         OP_MUL_R_R: begin
            prod = mRegs[d] * mRegs[s];
            mCarry = (prod / 256 != 0) ? 1 : 0;
            mRegs[d] = prod % 256;
            lat = 9;
         end
         default: mCarry = 0;
      endcase
      mPc = nextPc;
   endtask

   // Issue one instruction, wait for its retirement and compare everything visible.
   task automatic applyStimulus(input string tag, input exec_op_e o, input int d, input int s,
                                input int im, input int sw);
      int expLat;
      int lat;
      int lowReady;
      modelExec(o, d, s, im, sw, expLat);
      op        = o;
      rd        = 2'(d);
      rs        = 2'(s);
      imm       = 8'(im);
      switch_in = 8'(sw);
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat       = 1;
      lowReady  = 0;
      while (!done && lat < 40) begin
         if (!req_ready) lowReady++;
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, "_latency"}, lat, expLat);
      checkOutput({tag, "_ready_low"}, lowReady, expLat - 1);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_pc"}, pc, mPc);
      checkOutput({tag, "_out"}, out_port, mOut);
      checkOutput({tag, "_carry"}, carry, mCarry);
   endtask

   task automatic dumpRegs(input string tag);
      for (int i = 0; i < 4; i++) begin
         applyStimulus({tag, "_dump"}, OP_OUT_R, i, 0, 0, 0);
      end
   endtask

   initial begin
      int expLat;
      int lat;
      int savedPc;
      req_valid = 1'b0;
      op        = OP_NOP;
      rd        = '0;
      rs        = '0;
      imm       = '0;
      switch_in = '0;
      rst       = 1'b1;
      modelReset();
      #12;
      checkOutput("reset_pc", pc, 0);
      checkOutput("reset_carry", carry, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_ready", req_ready, 1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset in ITER cycle 3 of a MUL: nothing commits, no done.
      applyStimulus("t1_mov1", OP_MOV_R_IMM, 1, 0, 8'h13, 0);
      applyStimulus("t1_mov2", OP_MOV_R_IMM, 2, 0, 8'h0E, 0);
      op = OP_MUL_R_R; rd = 2'd1; rs = 2'd2; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("t1_busy_iter", busy, 1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t1_rst_pc", pc, 0);
      checkOutput("t1_rst_carry", carry, 0);
      checkOutput("t1_rst_done", done, 0);
      checkOutput("t1_rst_ready", req_ready, 1);
      @(posedge clk);
      #3;
      rst = 1'b0;
      modelReset();
      for (int k = 0; k < 10; k++) begin
         @(posedge clk);
         #1;
         checkOutput("t1_no_done", done, 0);
      end
      checkOutput("t1_ready_after", req_ready, 1);
      dumpRegs("t1");

      // ADD with carry-out, then JNC falls through and clears carry.
      applyStimulus("t2_mov", OP_MOV_R_IMM, 0, 0, 8'hF0, 0);
      applyStimulus("t2_add", OP_ADD_R_IMM, 0, 0, 8'h20, 0);
      checkOutput("t2_add_carry", carry, 1);
      savedPc = int'(pc);
      applyStimulus("t2_jnc", OP_JNC_IMM, 0, 0, 8'h40, 0);
      checkOutput("t2_jnc_pc", pc, (savedPc + 1) % 256);
      checkOutput("t2_jnc_carry", carry, 0);
      applyStimulus("t2_out", OP_OUT_R, 0, 0, 0, 0);
      checkOutput("t2_r0", out_port, 8'h10);

      // MUL 0x13 * 0x0E = 0x10A.
      applyStimulus("t3_mov1", OP_MOV_R_IMM, 1, 0, 8'h13, 0);
      applyStimulus("t3_mov2", OP_MOV_R_IMM, 2, 0, 8'h0E, 0);
      applyStimulus("t3_mul", OP_MUL_R_R, 1, 2, 0, 0);
      checkOutput("t3_mul_carry", carry, 1);
      applyStimulus("t3_out", OP_OUT_R, 1, 0, 0, 0);
      checkOutput("t3_r1", out_port, 8'h0A);

      // SHL by 1 and by 0.
      applyStimulus("t4_mov", OP_MOV_R_IMM, 3, 0, 8'h81, 0);
      applyStimulus("t4_shl1", OP_SHL_R_IMM, 3, 0, 1, 0);
      checkOutput("t4_shl1_carry", carry, 1);
      applyStimulus("t4_shl0", OP_SHL_R_IMM, 3, 0, 0, 0);
      checkOutput("t4_shl0_carry", carry, 0);
      applyStimulus("t4_out", OP_OUT_R, 3, 0, 0, 0);
      checkOutput("t4_r3", out_port, 8'h02);

      // PC wrap and SUB borrow.
      applyStimulus("t5_jmp", OP_JMP_IMM, 0, 0, 8'hFF, 0);
      checkOutput("t5_pc_ff", pc, 8'hFF);
      applyStimulus("t5_nop", OP_NOP, 0, 0, 0, 0);
      checkOutput("t5_pc_wrap", pc, 0);
      applyStimulus("t5_mov0", OP_MOV_R_IMM, 0, 0, 8'h03, 0);
      applyStimulus("t5_mov1", OP_MOV_R_IMM, 1, 0, 8'h05, 0);
      applyStimulus("t5_sub", OP_SUB_R_R, 0, 1, 0, 0);
      checkOutput("t5_sub_carry", carry, 1);
      applyStimulus("t5_out", OP_OUT_R, 0, 0, 0, 0);
      checkOutput("t5_r0", out_port, 8'hFE);

      // req_valid held across a MUL: next instruction taken on the first IDLE edge.
      applyStimulus("t6_mov1", OP_MOV_R_IMM, 1, 0, 8'h07, 0);
      applyStimulus("t6_mov2", OP_MOV_R_IMM, 2, 0, 8'h03, 0);
      modelExec(OP_MUL_R_R, 1, 2, 0, 0, expLat);
      op = OP_MUL_R_R; rd = 2'd1; rs = 2'd2; req_valid = 1'b1;
      @(posedge clk);
      #1;
      op = OP_OUT_IMM; rd = 2'd0; imm = 8'h5A;
      lat = 1;
      while (!done && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput("t6_mul_latency", lat, expLat);
      checkOutput("t6_ready_idle", req_ready, 1);
      checkOutput("t6_mul_pc", pc, mPc);
      modelExec(OP_OUT_IMM, 0, 0, 8'h5A, 0, expLat);
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      checkOutput("t6_second_done", done, 1);
      checkOutput("t6_second_out", out_port, 8'h5A);
      checkOutput("t6_second_pc", pc, mPc);
      @(posedge clk);
      #1;
      checkOutput("t6_done_drop", done, 0);
      applyStimulus("t6_in", OP_IN_R, 3, 0, 0, 8'hA5);
      applyStimulus("t6_out", OP_OUT_R, 3, 0, 0, 0);
      checkOutput("t6_switch_out", out_port, 8'hA5);
      dumpRegs("t6");

      // Randomized instruction stream, including undefined opcodes.
      for (int k = 0; k < 80; k++) begin
         applyStimulus("rnd", exec_op_e'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                       int'($urandom_range(0, 255)));
         if (k % 20 == 19) dumpRegs("rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
